cla_seq_ctrl: RTL



---
 rtl/cla_seq_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cla_seq_ctrl.sv
// Nibble-serial add/subtract sequencer wrapped around one 4-bit carry-lookahead slice.
// The carry-out of each nibble is registered and becomes the carry-in of the next nibble.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co3,
  output logic       co4
);
  logic [3:0] g, p;
  logic       c1, c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum-of-products of g, p and cin; none depends on another carry.
  assign c1  = g[0] | (p[0] & cin);
  assign c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign co3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign co4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
  assign s   = p ^ {co3, c2, c1, cin};
endmodule

module cla_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t           state, nstate;
  logic [W-1:0]  a_r, b_r, working, work_nxt;
  logic          sub_r, carry;
  logic [KW-1:0] k;
  logic          accept, last;
  logic [3:0]    bk, s;
  logic          c3, c4;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (k == KW'(NIBBLES - 1));
  assign bk     = b_r[4*k +: 4] ^ {4{sub_r}};

  cla4 u_cla (
    .a   (a_r[4*k +: 4]),
    .b   (bk),
    .cin (carry),
    .s   (s),
    .co3 (c3),
    .co4 (c4)
  );

  // Final sum must include the nibble being computed on the last RUN cycle.
  always_comb begin
    work_nxt          = working;
    work_nxt[4*k +: 4] = s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = start ? RUN : IDLE;
      RUN:     nstate = last ? DONE : RUN;
      DONE:    nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      carry   <= 1'b0;
      k       <= '0;
      working <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      sub_r   <= sub;
      carry   <= sub;
      k       <= '0;
      working <= '0;
    end else if (state == RUN) begin
      working <= work_nxt;
      carry   <= c4;
      if (last) begin
        sum  <= work_nxt;
        cout <= c4;
        ovf  <= c3 ^ c4;
      end else begin
        k <= k + 1'b1;
      end
    end
  end
endmodule
